best_gain_finder: RTL and testbench
===================================

# best_gain_finder

Downstream consumer of the stochastic-phase control unit's enable outputs. When enabled, it scans a snapshot of the enabled clauses in index order and fetches each clause's signed gain over a request/valid handshake. It tracks the maximum gain and its clause index, then holds `out_done` high. That `out_done` is the `in_local_done` the stochastic control unit waits on.

## Interface
- `MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX`, default 2: clause index width; N = 2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX clauses.
- `GAIN_WIDTH`, default 8: width of the two's-complement signed gain.

Ports:
- `in_clk`  input  1: single clock; all registers update on its rising edge.
- `in_reset`  input  1: synchronous, active-high reset.
- `in_enable`  input  1: start/hold; driven by the control unit's find-best-gain enable.
- `in_clauses_enable`  input  N: existing/enabled clause mask; bit i covers clause i.
- `in_gain`  input  GAIN_WIDTH: signed gain of the currently requested clause.
- `in_gain_valid`  input  1: `in_gain` valid; sampled only in WAIT_GAIN.
- `out_gain_request`  output  1: gain requested for `out_clause_index`.
- `out_clause_index`  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX: clause currently being scanned.
- `out_best_index`  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX: index of the best gain.
- `out_best_gain`  output  GAIN_WIDTH: best signed gain.
- `out_best_valid`  output  1: at least one enabled clause was evaluated.
- `out_done`  output  1: scan complete; result stable.

## Operation
- **Reset.** Every output and register is 0, including `out_best_gain`, and the state is IDLE. Reset wins over all other inputs, including mid-scan.
- **Result registers.** `out_best_*` are registered. They clear only on reset or at scan start, and otherwise hold between scans.
- **IDLE.** `out_done` = 0 and `out_gain_request` = 0. On `in_enable` = 1:
  - snapshot `in_clauses_enable` into the mask register;
  - clear the index, `out_best_valid`, `out_best_index` and `out_best_gain` to 0;
  - go to CHECK.
- **CHECK** (one cycle per index). Examine mask bit `idx`:
  - bit set: go to WAIT_GAIN;
  - bit clear and `idx` = N-1: go to DONE;
  - bit clear otherwise: `idx` + 1, stay in CHECK.
- **WAIT_GAIN.**
  - `out_gain_request` = 1 and is held until `in_gain_valid` is sampled high. The gain source may take any number of cycles.
  - On valid, compare `in_gain` as signed. Update the best registers if `out_best_valid` = 0 or `in_gain` > `out_best_gain`, then set `out_best_valid` = 1.
  - Ties keep the earlier, lower index.
  - Next state: DONE if `idx` = N-1, else `idx` + 1 and CHECK.
- **DONE.** `out_done` = 1 and results are stable. Stay while `in_enable` = 1. On `in_enable` = 0, go to IDLE, where `out_done` drops and results are retained.
- **Abort.** `in_enable` = 0 in CHECK or WAIT_GAIN goes to IDLE with no `out_done` and no further best update. A valid arriving in that same cycle is ignored.
- **Snapshot.** Changes to `in_clauses_enable` during a scan are ignored.
- **Stray valid.** `in_gain_valid` outside WAIT_GAIN is ignored.
- **Empty mask.** The scan still walks all N indices. It ends with `out_best_valid` = 0, `out_best_index` = 0 and `out_best_gain` = 0.
- **Signed extremes.** The most-negative gain is a legal best when it is the first or only enabled gain.

## Timing
- **Outputs.** All outputs are driven from registers or the state only, with no combinational input-to-output path.
- **Start.** Edge E0 samples `in_enable` = 1, and CHECK of idx 0 is in the following cycle.
- **Latency.** Edges from E0 to `out_done` rising = N + Σ over enabled clauses of (W_i). W_i is the number of WAIT_GAIN cycles up to and including the one where valid is sampled, with W_i ≥ 1.
- **Index timing.** `out_clause_index` is stable for the whole WAIT_GAIN interval and changes only on the state transition out of it.
- **Restart.** After `in_enable` falls in DONE, one IDLE cycle follows; a new scan may start on the next edge.

## Test plan
- **Reset mid-scan.** Assert `in_reset` in WAIT_GAIN → next cycle all outputs 0, IDLE, `out_gain_request` = 0.
- **All enabled, same-cycle valid.** N=4, mask 4'b1111, `in_gain_valid` tied high, gains {3, -2, 7, 7} → `out_done` rises 8 edges after E0, `out_best_index` = 2, `out_best_gain` = 7, `out_best_valid` = 1.
- **Sparse mask with stall.** Mask 4'b1010, gain valid after 3 request cycles, gains idx1 = -128, idx3 = -5 → best idx 3, gain -5, `out_done` 4+3+3 = 10 edges after E0.
- **Empty mask.** Mask 0 → `out_done` 4 edges after E0, `out_best_valid` = 0, `out_gain_request` never asserted.
- **Abort then clean restart.** Drop `in_enable` in WAIT_GAIN with valid asserted that cycle → no `out_done`, best not updated. Restart with mask 4'b0001, gain 5 → best idx 0, gain 5.
- **Snapshot and stray valid.** Toggle `in_clauses_enable` mid-scan and pulse `in_gain_valid` in CHECK → result matches the E0 snapshot and the stray pulse has no effect.

Source files
------------

// File: rtl/best_gain_finder.sv
// Scans a snapshot of enabled clauses in index order, fetches each clause's signed
// gain over a request/valid handshake, and reports the maximum gain and its index.
module best_gain_finder #(
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 2,
  parameter int GAIN_WIDTH                         = 8
) (
  input  logic                                          in_clk,
  input  logic                                          in_reset,
  input  logic                                          in_enable,
  input  logic [(1<<MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_clauses_enable,
  input  logic [GAIN_WIDTH-1:0]                         in_gain,
  input  logic                                          in_gain_valid,
  output logic                                          out_gain_request,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_best_index,
  output logic [GAIN_WIDTH-1:0]                         out_best_gain,
  output logic                                          out_best_valid,
  output logic                                          out_done
);

  localparam int IW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int N  = 1 << IW;
  localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WAIT_GAIN = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                 state_q;
  logic [N-1:0]           mask_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          best_idx_q;
  logic [GAIN_WIDTH-1:0]  best_gain_q;
  logic                   best_valid_q;

  // Strict greater-than keeps the earlier (lower) index on ties.
  logic gain_better;
  assign gain_better = !best_valid_q || ($signed(in_gain) > $signed(best_gain_q));

  // NOTE: all state lives in one clocked block using non-blocking assignments, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_gain_q  <= '0;
      best_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_enable) begin
            mask_q       <= in_clauses_enable;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_gain_q  <= '0;
            best_valid_q <= 1'b0;
            state_q      <= CHECK;
          end
        end
        CHECK: begin
          if (!in_enable) begin
            state_q <= IDLE;
          end else if (mask_q[idx_q]) begin
            state_q <= WAIT_GAIN;
          end else if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        WAIT_GAIN: begin
          // An abort takes priority over a valid gain arriving in the same cycle.
          if (!in_enable) begin
            state_q <= IDLE;
          end else if (in_gain_valid) begin
            if (gain_better) begin
              best_idx_q  <= idx_q;
              best_gain_q <= in_gain;
            end
            best_valid_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= CHECK;
            end
          end
        end
        DONE: begin
          if (!in_enable) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign out_gain_request = (state_q == WAIT_GAIN);
  assign out_done         = (state_q == DONE);
  assign out_clause_index = idx_q;
  assign out_best_index   = best_idx_q;
  assign out_best_gain    = best_gain_q;
  assign out_best_valid   = best_valid_q;

endmodule

// File: tb/tb_best_gain_finder.sv
// Scoreboard bench for best_gain_finder: directed scans push expected results,
// a monitor compares them when out_done rises.
module tb_best_gain_finder;

  localparam int IW = 2;
  localparam int N  = 4;
  localparam int GW = 8;

  logic          in_clk = 1'b0;
  logic          in_reset;
  logic          in_enable;
  logic [N-1:0]  in_clauses_enable;
  logic [GW-1:0] in_gain;
  logic          in_gain_valid;
  logic          out_gain_request;
  logic [IW-1:0] out_clause_index;
  logic [IW-1:0] out_best_index;
  logic [GW-1:0] out_best_gain;
  logic          out_best_valid;
  logic          out_done;

  best_gain_finder #(
    .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(IW),
    .GAIN_WIDTH(GW)
  ) dut (
    .in_clk(in_clk),
    .in_reset(in_reset),
    .in_enable(in_enable),
    .in_clauses_enable(in_clauses_enable),
    .in_gain(in_gain),
    .in_gain_valid(in_gain_valid),
    .out_gain_request(out_gain_request),
    .out_clause_index(out_clause_index),
    .out_best_index(out_best_index),
    .out_best_gain(out_best_gain),
    .out_best_valid(out_best_valid),
    .out_done(out_done)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    int idx;
    int gain;
    int valid;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   req_cnt = 0;
  logic done_prev = 1'b0;

  // Gain source: mode 0 manual, 1 valid tied high, 2 valid after `delay` request cycles.
  int            mode = 0;
  int            delay = 1;
  int            wcnt = 0;
  logic          man_valid = 1'b0;
  logic [GW-1:0] man_gain = '0;
  logic          auto_valid = 1'b0;
  logic [GW-1:0] gain_tbl [N];

  assign in_gain_valid = (mode == 0) ? man_valid : auto_valid;
  assign in_gain       = (mode == 0) ? man_gain  : gain_tbl[out_clause_index];

  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (mode == 1) begin
      auto_valid = 1'b1;
    end else if (mode == 2 && out_gain_request) begin
      wcnt = wcnt + 1;
      auto_valid = (wcnt >= delay);
    end else begin
      wcnt = 0;
      auto_valid = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts requests and scores every rising out_done against the queue.
  always @(negedge in_clk) begin
    if (out_gain_request) req_cnt++;
    if (out_done && !done_prev) begin
      check("done_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("best_index", int'(out_best_index), e.idx);
        check("best_gain", int'($signed(out_best_gain)), e.gain);
        check("best_valid", int'(out_best_valid), e.valid);
        check("done_cycle", cyc, e.cyc);
      end
    end
    done_prev = out_done;
  end

  task automatic set_gains(input int g0, input int g1, input int g2, input int g3);
    gain_tbl[0] = GW'(g0);
    gain_tbl[1] = GW'(g1);
    gain_tbl[2] = GW'(g2);
    gain_tbl[3] = GW'(g3);
  endtask

  // Starts a scan; lat = edges from E0 to out_done rising (0 = no done expected).
  task automatic start_scan(input logic [N-1:0] mask, input int eidx, input int egain,
                            input int evalid, input int lat);
    exp_t e;
    @(negedge in_clk);
    in_clauses_enable = mask;
    in_enable = 1'b1;
    if (lat > 0) begin
      e.idx = eidx; e.gain = egain; e.valid = evalid; e.cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
  endtask

  task automatic finish_scan(input int egain);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge in_clk);
      seen = out_done;
    end
    check("done_within_budget", int'(seen), 1);
    @(negedge in_clk);
    check("done_held", int'(out_done), 1);
    in_enable = 1'b0;
    @(negedge in_clk);
    check("done_drops", int'(out_done), 0);
    check("gain_retained", int'($signed(out_best_gain)), egain);
  endtask

  task automatic wait_request();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge in_clk);
      seen = out_gain_request;
    end
    check("request_within_budget", int'(seen), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request"}, int'(out_gain_request), 0);
    check({tag, "_index"}, int'(out_clause_index), 0);
    check({tag, "_best_index"}, int'(out_best_index), 0);
    check({tag, "_best_gain"}, int'(out_best_gain), 0);
    check({tag, "_best_valid"}, int'(out_best_valid), 0);
    check({tag, "_done"}, int'(out_done), 0);
  endtask

  initial begin
    int req_before;
    in_reset = 1'b1;
    in_enable = 1'b0;
    in_clauses_enable = '0;
    set_gains(0, 0, 0, 0);
    repeat (2) @(negedge in_clk);
    check_all_zero("reset");
    in_reset = 1'b0;

    // All enabled, valid tied high, tie at 7 keeps index 2.
    mode = 1;
    set_gains(3, -2, 7, 7);
    start_scan(4'b1111, 2, 7, 1, 8);
    finish_scan(7);

    // Sparse mask with a 3-cycle stall per gain.
    mode = 2; delay = 3;
    set_gains(99, -128, 99, -5);
    start_scan(4'b1010, 3, -5, 1, 10);
    finish_scan(-5);

    // Most-negative gain as the only enabled gain.
    mode = 1;
    set_gains(10, -128, 10, 10);
    start_scan(4'b0010, 1, -128, 1, 5);
    finish_scan(-128);

    // Empty mask: walk all indices, never request, stray valid tied high.
    req_before = req_cnt;
    start_scan(4'b0000, 0, 0, 0, 4);
    finish_scan(0);
    check("empty_no_request", req_cnt - req_before, 0);

    // Abort in WAIT_GAIN with a valid in the same cycle.
    mode = 0; man_valid = 1'b0; man_gain = 8'd100;
    start_scan(4'b1111, 0, 0, 0, 0);
    wait_request();
    in_enable = 1'b0;
    man_valid = 1'b1;
    @(negedge in_clk);
    man_valid = 1'b0;
    check("abort_request", int'(out_gain_request), 0);
    check("abort_done", int'(out_done), 0);
    check("abort_best_valid", int'(out_best_valid), 0);
    check("abort_best_gain", int'(out_best_gain), 0);

    // Clean restart.
    mode = 1;
    set_gains(5, 0, 0, 0);
    start_scan(4'b0001, 0, 5, 1, 5);
    finish_scan(5);

    // Snapshot: mask change after E0 and valid pulsing in CHECK are ignored.
    set_gains(-3, 50, -7, 60);
    start_scan(4'b0101, 0, -3, 1, 6);
    @(negedge in_clk);
    in_clauses_enable = 4'b1111;
    finish_scan(-3);

    // Reset mid-scan while waiting for a gain.
    mode = 0; man_valid = 1'b0;
    start_scan(4'b1111, 0, 0, 0, 0);
    wait_request();
    in_reset = 1'b1;
    @(negedge in_clk);
    check_all_zero("midreset");
    in_reset = 1'b0;
    in_enable = 1'b0;

    repeat (5) @(negedge in_clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
